// File: rtl/wb_pkg.sv
// Purpose: shared types for the register-file writeback arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_pkg;

    // Depth of the ALU skid FIFO. wb_skid_fifo stores its entries in two
    // discrete registers, so changing this also means changing that module.
    localparam int FIFO_DEPTH = 2;

    // Which source drives the register-file write port this cycle.
    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_FIFO = 3'd1,
        SRC_ALU  = 3'd2,
        SRC_LSU  = 3'd3,
        SRC_LNK  = 3'd4
    } src_sel_t;

    // One buffered ALU writeback.
    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } alu_entry_t;

endpackage

// File: rtl/wb_skid_fifo.sv
// Purpose: 2-entry skid buffer for ALU writebacks that lost the port.
// Latency: push visible at head the cycle after; push and pop may share a cycle.
// Backpressure: none; the arbiter never pushes into a full FIFO unless it pops.
//
// Ports: clk, reset_n (sync, active-low); push/push_entry enqueue; pop dequeues
// head; empty/full status; probe_addr/probe_hit report whether any held entry
// targets probe_addr (write-after-write guard).
module wb_skid_fifo
    import wb_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push,
    input  alu_entry_t push_entry,
    input  logic       pop,
    input  logic [4:0] probe_addr,
    output alu_entry_t head,
    output logic       empty,
    output logic       full,
    output logic       probe_hit
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    alu_entry_t       ent0;  // head
    alu_entry_t       ent1;
    logic [CW-1:0]    cnt;

    assign head      = ent0;
    assign empty     = (cnt == '0);
    assign full      = (cnt == CW'(FIFO_DEPTH));
    assign probe_hit = (!empty && ent0.addr == probe_addr) ||
                       (full   && ent1.addr == probe_addr);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ent0 <= '0;
            ent1 <= '0;
            cnt  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (empty) ent0 <= push_entry;
                    else       ent1 <= push_entry;
                    cnt <= cnt + CW'(1);
                end
                2'b01: begin
                    ent0 <= ent1;
                    cnt  <= cnt - CW'(1);
                end
                2'b11: begin
                    // Occupancy unchanged: the new entry lands behind whatever
                    // remains after the pop.
                    if (cnt == CW'(1)) begin
                        ent0 <= push_entry;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Purpose: arbitrates ALU, LSU and jump-link writebacks onto one RF write port.
// Latency: rf_write_* registered, 1 cycle after the winner is selected.
// Backpressure: LSU/LNK held off via combinational *_ready; ALU never stalls (skid FIFO).
//
// Ports: clk, reset_n (sync, active-low); alu_write_*: ALU pulse writes;
// lsu_*/lnk_*: valid/ready writeback requests; rf_write_*: registered RF port;
// busy: skid FIFO non-empty. With WB_ARBITER_STATS_EN defined an extra
// stall_cnt output counts cycles a non-x0 LSU/LNK request is held off.
// STARVE_LIMIT must be at least 1.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        alu_write_req,
    input  logic [4:0]  alu_write_addr,
    input  logic [31:0] alu_write_data,
    input  logic        lsu_valid,
    input  logic [4:0]  lsu_addr,
    input  logic [31:0] lsu_data,
    output logic        lsu_ready,
    input  logic        lnk_valid,
    input  logic [4:0]  lnk_addr,
    input  logic [31:0] lnk_data,
    output logic        lnk_ready,
    output logic        rf_write_req,
    output logic [4:0]  rf_write_addr,
    output logic [31:0] rf_write_data,
    output logic        busy
`ifdef WB_ARBITER_STATS_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic             alu_act, lsu_req, lnk_req, lsu_x0, lnk_x0, any_req;
    logic             pick_lsu, override, alu_waw;
    logic [4:0]       rr_addr;
    logic             fifo_empty, fifo_full, fifo_hit, push, pop;
    alu_entry_t       head, alu_entry;
    src_sel_t         sel;
    logic [4:0]       sel_addr;
    logic [31:0]      sel_data;
    logic [CNT_W-1:0] starve_cnt;
    logic             prec_lsu;  // round-robin: LSU goes first when both wait

    // x0 writes are architecturally void: they never compete for the port.
    assign alu_act  = alu_write_req && (alu_write_addr != '0);
    assign lsu_req  = lsu_valid && (lsu_addr != '0);
    assign lnk_req  = lnk_valid && (lnk_addr != '0);
    assign lsu_x0   = lsu_valid && (lsu_addr == '0);
    assign lnk_x0   = lnk_valid && (lnk_addr == '0);
    assign any_req  = lsu_req || lnk_req;
    assign pick_lsu = lsu_req && (!lnk_req || prec_lsu);
    assign rr_addr  = pick_lsu ? lsu_addr : lnk_addr;

    assign alu_entry = '{addr: alu_write_addr, data: alu_write_data};
    assign alu_waw   = alu_act && (alu_write_addr == rr_addr);

    // Starvation override: the LSU/LNK winner jumps the ALU queue only if the
    // displaced ALU write has room in the FIFO and no pending ALU write to the
    // same rd would then land after it.
    assign override = any_req && (starve_cnt == CNT_W'(STARVE_LIMIT)) &&
                      !fifo_full && !fifo_hit && !alu_waw;

    always_comb begin
        sel = SRC_NONE;
        if (override)         sel = pick_lsu ? SRC_LSU : SRC_LNK;
        else if (!fifo_empty) sel = SRC_FIFO;
        else if (alu_act)     sel = SRC_ALU;
        else if (any_req)     sel = pick_lsu ? SRC_LSU : SRC_LNK;
    end

    // An ALU write that does not reach the port goes behind the FIFO head.
    // When the FIFO is full the override is off, so the head pops this cycle.
    assign push = alu_act && (!fifo_empty || override);
    assign pop  = (sel == SRC_FIFO);

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        case (sel)
            SRC_FIFO: begin sel_addr = head.addr;      sel_data = head.data;      end
            SRC_ALU:  begin sel_addr = alu_write_addr; sel_data = alu_write_data; end
            SRC_LSU:  begin sel_addr = lsu_addr;       sel_data = lsu_data;       end
            SRC_LNK:  begin sel_addr = lnk_addr;       sel_data = lnk_data;       end
            default: ;
        endcase
    end

    assign lsu_ready = reset_n && (lsu_x0 || sel == SRC_LSU);
    assign lnk_ready = reset_n && (lnk_x0 || sel == SRC_LNK);
    assign busy      = !fifo_empty;

    wb_skid_fifo u_skid (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (alu_entry),
        .pop        (pop),
        .probe_addr (rr_addr),
        .head       (head),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .probe_hit  (fifo_hit)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rf_write_req  <= 1'b0;
            rf_write_addr <= '0;
            rf_write_data <= '0;
            starve_cnt    <= '0;
            prec_lsu      <= 1'b1;
        end else begin
            rf_write_req  <= (sel != SRC_NONE);
            rf_write_addr <= sel_addr;
            rf_write_data <= sel_data;

            if (sel == SRC_LSU)      prec_lsu <= 1'b0;
            else if (sel == SRC_LNK) prec_lsu <= 1'b1;

            // Saturates at the limit so a WAW-blocked override stays armed
            // until the conflict clears.
            if (sel == SRC_LSU || sel == SRC_LNK || !any_req)
                starve_cnt <= '0;
            else if (starve_cnt != CNT_W'(STARVE_LIMIT))
                starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

`ifdef WB_ARBITER_STATS_EN
    always_ff @(posedge clk) begin
        if (!reset_n)
            stall_cnt <= '0;
        else if (((lsu_req && !lsu_ready) || (lnk_req && !lnk_ready)) && stall_cnt != '1)
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        alu_write_req;
    logic [4:0]  alu_write_addr;
    logic [31:0] alu_write_data;
    logic        lsu_valid;
    logic [4:0]  lsu_addr;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic        lnk_valid;
    logic [4:0]  lnk_addr;
    logic [31:0] lnk_data;
    logic        lnk_ready;
    logic        rf_write_req;
    logic [4:0]  rf_write_addr;
    logic [31:0] rf_write_data;
    logic        busy;
`ifdef WB_ARBITER_STATS_EN
    logic [31:0] stall_cnt;
`endif

    always #5 clk = ~clk;

    wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .alu_write_req  (alu_write_req),
        .alu_write_addr (alu_write_addr),
        .alu_write_data (alu_write_data),
        .lsu_valid      (lsu_valid),
        .lsu_addr       (lsu_addr),
        .lsu_data       (lsu_data),
        .lsu_ready      (lsu_ready),
        .lnk_valid      (lnk_valid),
        .lnk_addr       (lnk_addr),
        .lnk_data       (lnk_data),
        .lnk_ready      (lnk_ready),
        .rf_write_req   (rf_write_req),
        .rf_write_addr  (rf_write_addr),
        .rf_write_data  (rf_write_data),
        .busy           (busy)
`ifdef WB_ARBITER_STATS_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: a queue of deferred ALU writes, a starvation count and
    // the round-robin precedence, advanced one cycle per step.
    logic [4:0]  mq_addr[$];
    logic [31:0] mq_data[$];
    int          m_starve  = 0;
    bit          m_prec_lsu = 1'b1;
    bit          m_req;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    bit          acc_lsu, acc_lnk;        // model's view of this cycle's acceptances
    logic        obs_lsu_rdy, obs_lnk_rdy; // DUT readies sampled before the edge

    task automatic step(input bit rst,
                        input bit a_v, input logic [4:0] a_a, input logic [31:0] a_d,
                        input bit l_v, input logic [4:0] l_a, input logic [31:0] l_d,
                        input bit k_v, input logic [4:0] k_a, input logic [31:0] k_d);
        bit alu, lr, kr, pick_lsu, any, ovr, hit, push, e_lrdy, e_krdy;
        logic [4:0] ra;
        int who;  // 0 none, 1 fifo, 2 alu, 3 lsu, 4 lnk
        @(negedge clk);
        reset_n = !rst;
        alu_write_req = a_v; alu_write_addr = a_a; alu_write_data = a_d;
        lsu_valid = l_v; lsu_addr = l_a; lsu_data = l_d;
        lnk_valid = k_v; lnk_addr = k_a; lnk_data = k_d;

        alu = a_v && a_a != 0;
        lr  = l_v && l_a != 0;
        kr  = k_v && k_a != 0;
        any = lr || kr;
        pick_lsu = lr && (!kr || m_prec_lsu);
        ra  = pick_lsu ? l_a : k_a;
        hit = 1'b0;
        foreach (mq_addr[i]) if (mq_addr[i] == ra) hit = 1'b1;
        ovr = any && m_starve == LIMIT && mq_addr.size() < 2 && !hit && !(alu && a_a == ra);
        if (ovr)                      who = pick_lsu ? 3 : 4;
        else if (mq_addr.size() > 0)  who = 1;
        else if (alu)                 who = 2;
        else if (any)                 who = pick_lsu ? 3 : 4;
        else                          who = 0;
        e_lrdy = !rst && l_v && (l_a == 0 || who == 3);
        e_krdy = !rst && k_v && (k_a == 0 || who == 4);

        #1;
        obs_lsu_rdy = lsu_ready;
        obs_lnk_rdy = lnk_ready;
        check("lsu_ready", 32'(lsu_ready), 32'(e_lrdy));
        check("lnk_ready", 32'(lnk_ready), 32'(e_krdy));
        acc_lsu = e_lrdy;
        acc_lnk = e_krdy;

        if (rst) begin
            mq_addr.delete(); mq_data.delete();
            m_starve = 0; m_prec_lsu = 1'b1;
            m_req = 0; m_addr = 0; m_data = 0;
        end else begin
            push  = alu && (mq_addr.size() > 0 || ovr);
            m_req = (who != 0);
            case (who)
                1: begin m_addr = mq_addr.pop_front(); m_data = mq_data.pop_front(); end
                2: begin m_addr = a_a; m_data = a_d; end
                3: begin m_addr = l_a; m_data = l_d; end
                4: begin m_addr = k_a; m_data = k_d; end
                default: ;
            endcase
            if (push) begin mq_addr.push_back(a_a); mq_data.push_back(a_d); end
            if (who == 3 || who == 4) begin
                m_starve = 0;
                m_prec_lsu = (who == 4);
            end else if (!any) begin
                m_starve = 0;
            end else begin
                m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
            end
        end

        @(posedge clk);
        #1;
        check("rf_write_req", 32'(rf_write_req), 32'(m_req));
        if (m_req) begin
            check("rf_write_addr", 32'(rf_write_addr), 32'(m_addr));
            check("rf_write_data", rf_write_data, m_data);
        end
        check("busy", 32'(busy), 32'(mq_addr.size() != 0));
    endtask

    task automatic idle(input bit rst);
        step(rst, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
    endtask

    initial begin
        bit lp, kp, lsu_done, lnk_done;
        logic [4:0]  la, ka;
        logic [31:0] ld, kd;

        idle(1); idle(1);
        check("reset_req", 32'(rf_write_req), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);

        // Lone ALU write to x5.
        step(0, 1, 5'd5, 32'h1234, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        check("alu_only_req", 32'(rf_write_req), 32'd1);
        check("alu_only_addr", 32'(rf_write_addr), 32'd5);
        check("alu_only_data", rf_write_data, 32'h1234);
        idle(0);
        check("idle_req", 32'(rf_write_req), 32'd0);

        // LSU and LNK together: LSU first, then LNK.
        idle(1);
        step(0, 0, 5'd0, 32'd0, 1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2);
        check("rr_first_lsu", 32'(obs_lsu_rdy), 32'd1);
        check("rr_first_addr", 32'(rf_write_addr), 32'd1);
        step(0, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1, 5'd2, 32'hB2);
        check("rr_second_lnk", 32'(obs_lnk_rdy), 32'd1);
        check("rr_second_data", rf_write_data, 32'hB2);

        // Starvation override: LSU x7 against continuous ALU writes to x3.
        idle(1);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 5'd3, 32'h300 + 32'(i), 1, 5'd7, 32'h777, 0, 5'd0, 32'd0);
            check("starve_lsu_rdy", 32'(obs_lsu_rdy), (i == 4) ? 32'd1 : 32'd0);
            check("starve_addr", 32'(rf_write_addr), (i == 4) ? 32'd7 : 32'd3);
        end
        check("starve_busy", 32'(busy), 32'd1);
        idle(0);
        check("drain_data", rf_write_data, 32'h304);
        check("drain_busy", 32'(busy), 32'd0);

        // Same, but ALU targets x7: no override until the ALU stops.
        idle(1);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 5'd7, 32'h700 + 32'(i), 1, 5'd7, 32'h999, 0, 5'd0, 32'd0);
            check("waw_hold", 32'(obs_lsu_rdy), 32'd0);
        end
        step(0, 0, 5'd0, 32'd0, 1, 5'd7, 32'h999, 0, 5'd0, 32'd0);
        check("waw_release", 32'(obs_lsu_rdy), 32'd1);
        check("waw_release_data", rf_write_data, 32'h999);

        // LNK to x0 during an ALU write.
        step(0, 1, 5'd4, 32'h44, 0, 5'd0, 32'd0, 1, 5'd0, 32'hDEAD);
        check("x0_lnk_rdy", 32'(obs_lnk_rdy), 32'd1);
        check("x0_alu_addr", 32'(rf_write_addr), 32'd4);
        idle(0);
        check("x0_no_write", 32'(rf_write_req), 32'd0);

        // Fill FIFO to 2 entries via two overrides, then reset.
        idle(1);
        lsu_done = 0; lnk_done = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 5'd3, 32'h500 + 32'(i), !lsu_done, 5'd7, 32'h70, !lnk_done, 5'd8, 32'h80);
            if (acc_lsu) lsu_done = 1;
            if (acc_lnk) lnk_done = 1;
        end
        check("full_lnk_granted", 32'(lnk_done), 32'd1);
        check("full_busy", 32'(busy), 32'd1);
        step(1, 1, 5'd3, 32'h5FF, 0, 5'd0, 32'd0, 0, 5'd0, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req", 32'(rf_write_req), 32'd0);
        idle(0);
        check("rst_no_stale1", 32'(rf_write_req), 32'd0);
        idle(0);
        check("rst_no_stale2", 32'(rf_write_req), 32'd0);

        // Randomized traffic; requesters hold requests until accepted.
        lp = 0; kp = 0; la = 0; ka = 0; ld = 0; kd = 0;
        for (int n = 0; n < 3000; n++) begin
            bit rst, av;
            logic [4:0] aa;
            logic [31:0] ad;
            if (!lp) begin lp = ($urandom % 3) == 0; la = 5'($urandom % 8); ld = $urandom; end
            if (!kp) begin kp = ($urandom % 3) == 0; ka = 5'($urandom % 8); kd = $urandom; end
            av  = ($urandom % 4) != 0;
            aa  = 5'($urandom % 8);
            ad  = $urandom;
            rst = ($urandom % 300) == 0;
            step(rst, av, aa, ad, lp, la, ld, kp, ka, kd);
            if (acc_lsu || rst) lp = 0;
            if (acc_lnk || rst) kp = 0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning consecutive ALU-won cycles before a waiting LSU/LNK request overrides the ALU.
REQ-002 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have ports alu_write_req / alu_write_addr / alu_write_data  input  1/5/32  ALU writeback; no backpressure, single-cycle pulse per write.
REQ-005 SHALL have ports lsu_valid / lsu_addr / lsu_data  input  1/5/32  load-unit writeback request.
REQ-006 SHALL have port lsu_ready  output  1  LSU request accepted this cycle; combinational.
REQ-007 SHALL have ports lnk_valid / lnk_addr / lnk_data  input  1/5/32  jump-link writeback request.
REQ-008 SHALL have port lnk_ready  output  1  LNK request accepted this cycle; combinational.
REQ-009 SHALL have ports rf_write_req / rf_write_addr / rf_write_data  output  1/5/32  registered register-file write port.
REQ-010 SHALL have port busy  output  1  ALU skid FIFO non-empty.

Function
REQ-011 SHALL transfer an LSU/LNK request on the cycle valid&ready is high; requesters hold valid, addr and data stable until accepted.
REQ-012 SHALL produce rf_write_* exactly 1 cycle after the winning request is selected; rf_write_req is low in cycles with no winner.
REQ-013 SHALL drop writes with addr 0 without using the port: the ALU x0 write does not compete; LSU/LNK x0 requests get ready=1 the same cycle, even while another source wins.
REQ-014 SHALL contain a 2-entry ALU skid FIFO (addr+data); when it is non-empty, its head wins the port, and any new ALU write is pushed behind it (push+pop in one cycle allowed).
REQ-015 SHALL apply this priority order: FIFO head; direct ALU write; then round-robin between LSU and LNK.
REQ-016 SHALL give round-robin precedence to the requester not granted last; the pointer updates only on a real LSU/LNK grant; reset precedence is LSU.
REQ-017 SHALL count consecutive cycles in which ALU or FIFO wins while a non-x0 LSU/LNK request waits; the counter clears on any LSU/LNK grant or when no request is waiting.
REQ-018 SHALL let the round-robin LSU/LNK winner take the port when the count equals STARVE_LIMIT, FIFO count <2, and no FIFO entry or incoming ALU write targets the same rd; the incoming ALU write is pushed instead, and the counter clears.
REQ-019 SHALL never overflow the FIFO, because the override is disallowed at count 2 and a full FIFO always pops.
REQ-020 SHALL preserve write order to the same rd, per the WAW guard in REQ-018 and FIFO ordering.

Reset
REQ-021 SHALL on reset_n=0 at clk edge clear rf_write_req/addr/data to 0, the FIFO (entries lost), the starvation counter, and busy; round-robin precedence returns to LSU.
REQ-022 SHALL hold lsu_ready=lnk_ready=0 while reset_n=0.

Configuration
REQ-023 SHALL, with WB_ARBITER_STATS_EN defined, add output stall_cnt [31:0]: increments each cycle a non-x0 LSU/LNK valid is not ready, saturates at 0xFFFFFFFF, and resets to 0.
REQ-024 SHALL, without WB_ARBITER_STATS_EN, have no stall_cnt port or logic.

Structure
REQ-025 SHALL put the FIFO depth constant, the source-select encoding (NONE/FIFO/ALU/LSU/LNK) and the ALU writeback entry struct in shared package wb_pkg.
REQ-026 SHALL implement the skid FIFO as sub-module wb_skid_fifo; the arbitration logic stays in wb_arbiter.

Verification
REQ-027 SHALL cover: ALU write x5=0x1234 alone -> next cycle rf_write_req=1, addr 5, data 0x1234.
REQ-028 SHALL cover: LSU and LNK valid together, idle ALU -> LSU granted first, LNK next cycle, two writes in order.
REQ-029 SHALL cover: LSU x7 valid plus continuous ALU writes to x3 -> LSU granted on 5th cycle, ALU entry buffered, busy=1, then drained next cycle.
REQ-030 SHALL cover: as the previous scenario but the ALU targets x7 -> no override; LSU waits until the ALU stops.
REQ-031 SHALL cover: LNK to x0 during an ALU write -> lnk_ready=1 same cycle, no rf write for it.
REQ-032 SHALL cover: reset asserted with 2 FIFO entries -> next cycle busy=0, rf_write_req=0, no stale writes afterward.
